// File: rtl/draw_text_box.sv
// Text-overlay stage: draws a grid of 8x16 glyphs from external char/font ROMs
// over the pixel stream, with programmable ROM latency and frame-synced blink.
module draw_text_box #(
  parameter int unsigned COL_BITS     = 4,
  parameter int unsigned ROW_BITS     = 4,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned XPOS_DEF     = 350,
  parameter int unsigned YPOS_DEF     = 250,
  parameter logic [11:0] FG           = 12'h444,
  parameter logic [11:0] BG           = 12'h888,
  parameter bit          TRANSPARENT  = 1'b0,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic [10:0]                  hcount_in,
  input  logic [10:0]                  vcount_in,
  input  logic                         hsync_in,
  input  logic                         hblnk_in,
  input  logic                         vsync_in,
  input  logic                         vblnk_in,
  input  logic [11:0]                  rgb_in,
  input  logic [10:0]                  xpos,
  input  logic [10:0]                  ypos,
  input  logic                         blink_en,
  input  logic [7:0]                   char_pixels,
  output logic [10:0]                  hcount_out,
  output logic [10:0]                  vcount_out,
  output logic                         hsync_out,
  output logic                         hblnk_out,
  output logic                         vsync_out,
  output logic                         vblnk_out,
  output logic [11:0]                  rgb_out,
  output logic [ROW_BITS+COL_BITS-1:0] char_xy,
  output logic [3:0]                   char_line
);

  localparam int unsigned BOX_W = 8 << COL_BITS;
  localparam int unsigned BOX_H = 16 << ROW_BITS;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_box;
    logic [2:0]  px_idx;
  } side_t;

  logic             vblnk_prev_q;
  logic [10:0]      x0_q;
  logic [10:0]      y0_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             blink_phase_q;
  logic             frame_start_c;

  assign frame_start_c = vblnk_in && !vblnk_prev_q;

  // Box origin and blink state only change on a vblank rising edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_q  <= 1'b0;
      x0_q          <= 11'(XPOS_DEF);
      y0_q          <= 11'(YPOS_DEF);
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (frame_start_c) begin
        x0_q <= xpos;
        y0_q <= ypos;
        if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  logic [11:0] dx_c;
  logic [11:0] dy_c;
  logic        in_box_c;
  side_t       sb_in_c;

  // 12-bit offsets so a box running past 2047 clips rather than wraps.
  assign dx_c     = {1'b0, hcount_in} - {1'b0, x0_q};
  assign dy_c     = {1'b0, vcount_in} - {1'b0, y0_q};
  assign in_box_c = (hcount_in >= x0_q) && (dx_c < 12'(BOX_W)) &&
                    (vcount_in >= y0_q) && (dy_c < 12'(BOX_H));

  always_comb begin
    sb_in_c        = '0;
    sb_in_c.hcount = hcount_in;
    sb_in_c.vcount = vcount_in;
    sb_in_c.hsync  = hsync_in;
    sb_in_c.hblnk  = hblnk_in;
    sb_in_c.vsync  = vsync_in;
    sb_in_c.vblnk  = vblnk_in;
    sb_in_c.rgb    = rgb_in;
    sb_in_c.in_box = in_box_c;
    sb_in_c.px_idx = dx_c[2:0];
  end

  side_t sb_q [MEM_LAT+1];

  // Address stage plus sideband delay line matched to the ROM latency.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= MEM_LAT; i++) sb_q[i] <= '0;
      char_xy   <= '0;
      char_line <= '0;
    end else begin
      sb_q[0] <= sb_in_c;
      for (int unsigned i = 1; i <= MEM_LAT; i++) sb_q[i] <= sb_q[i-1];
      char_xy   <= in_box_c ? {dy_c[ROW_BITS+3:4], dx_c[COL_BITS+2:3]} : '0;
      char_line <= in_box_c ? dy_c[3:0] : 4'h0;
    end
  end

  side_t       sb_out_c;
  logic [2:0]  pix_idx_c;
  logic        pix_c;
  logic        hide_c;
  logic [11:0] rgb_c;

  assign sb_out_c  = sb_q[MEM_LAT];
  assign pix_idx_c = 3'd7 - sb_out_c.px_idx;
  assign pix_c     = char_pixels[pix_idx_c];
  assign hide_c    = blink_en && blink_phase_q && (BLINK_FRAMES != 0);

  always_comb begin
    rgb_c = TRANSPARENT ? sb_out_c.rgb : BG;
    if (sb_out_c.hblnk || sb_out_c.vblnk) begin
      rgb_c = 12'h000;
    end else if (!sb_out_c.in_box) begin
      rgb_c = sb_out_c.rgb;
    end else if (pix_c && !hide_c) begin
      rgb_c = FG;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= sb_out_c.hcount;
      vcount_out <= sb_out_c.vcount;
      hsync_out  <= sb_out_c.hsync;
      hblnk_out  <= sb_out_c.hblnk;
      vsync_out  <= sb_out_c.vsync;
      vblnk_out  <= sb_out_c.vblnk;
      rgb_out    <= rgb_c;
    end
  end

endmodule

// File: tb/tb_draw_text_box.sv
// Bench for draw_text_box: a default build and a MEM_LAT=1/TRANSPARENT/fast-blink
// build share one stimulus stream; a reference model feeds per-DUT scoreboards.
module tb_draw_text_box;

  typedef logic [37:0] exp_t;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] xpos = 11'd350, ypos = 11'd250;
  logic        blink_en = 1'b0;
  int          rom_mode = 0;

  logic [10:0] hco1, vco1, hco2, vco2;
  logic        hs1, hb1, vs1, vb1, hs2, hb2, vs2, vb2;
  logic [11:0] rgb1, rgb2;
  logic [7:0]  xy1, xy2;
  logic [3:0]  ln1, ln2;
  logic [7:0]  cp1, cp2;
  logic [7:0]  rom1_a = '0, rom1_b = '0, rom2_a = '0;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t q1[$];
  exp_t q2[$];

  int m_x0[2], m_y0[2], m_cnt[2];
  bit m_prev[2], m_phase[2];
  int bf_p[2] = '{30, 2};
  bit tr_p[2] = '{1'b0, 1'b1};

  always #5 pclk = ~pclk;

  draw_text_box u_dut1 (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .blink_en(blink_en), .char_pixels(cp1),
    .hcount_out(hco1), .vcount_out(vco1), .hsync_out(hs1), .hblnk_out(hb1),
    .vsync_out(vs1), .vblnk_out(vb1), .rgb_out(rgb1), .char_xy(xy1), .char_line(ln1)
  );

  draw_text_box #(.MEM_LAT(1), .TRANSPARENT(1'b1), .BLINK_FRAMES(2)) u_dut2 (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .blink_en(blink_en), .char_pixels(cp2),
    .hcount_out(hco2), .vcount_out(vco2), .hsync_out(hs2), .hblnk_out(hb2),
    .vsync_out(vs2), .vblnk_out(vb2), .rgb_out(rgb2), .char_xy(xy2), .char_line(ln2)
  );

  function automatic logic [7:0] glyph(input logic [7:0] xy, input logic [3:0] ln);
    return (rom_mode == 0) ? 8'h80 : (xy ^ {ln, ~ln});
  endfunction

  function automatic logic [11:0] rg(input int h, input int v);
    return 12'(h * 7 + v * 13) ^ 12'h5a5;
  endfunction

  // Font ROM models with 2 and 1 cycles of read latency.
  always @(posedge pclk) begin
    rom1_a <= glyph(xy1, ln1);
    rom1_b <= rom1_a;
    rom2_a <= glyph(xy2, ln2);
  end
  assign cp1 = rom1_b;
  assign cp2 = rom2_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_x0[d] = 350; m_y0[d] = 250; m_cnt[d] = 0; m_prev[d] = 1'b0; m_phase[d] = 1'b0;
    end
  endtask

  task automatic model(input int d, input logic [10:0] h, input logic [10:0] v,
                       input logic hs, input logic hb, input logic vs, input logic vb,
                       input logic [11:0] rgb, output exp_t e);
    int dx, dy, bi;
    logic ib, px, hide;
    logic [7:0] g;
    logic [11:0] c;
    dx = int'(h) - m_x0[d];
    dy = int'(v) - m_y0[d];
    ib = (dx >= 0) && (dx < 128) && (dy >= 0) && (dy < 256);
    px = 1'b0;
    if (ib) begin
      g  = glyph(8'((dy / 16) * 16 + dx / 8), 4'(dy % 16));
      bi = 7 - (dx % 8);
      px = g[bi];
    end
    hide = blink_en && m_phase[d] && (bf_p[d] != 0);
    if (hb || vb)        c = 12'h000;
    else if (!ib)        c = rgb;
    else if (px && !hide) c = 12'h444;
    else                 c = tr_p[d] ? rgb : 12'h888;
    e = {h, v, hs, hb, vs, vb, c};
    if (vb && !m_prev[d]) begin
      m_x0[d] = int'(xpos);
      m_y0[d] = int'(ypos);
      if (bf_p[d] != 0) begin
        if (m_cnt[d] == bf_p[d] - 1) begin
          m_cnt[d] = 0;
          m_phase[d] = !m_phase[d];
        end else begin
          m_cnt[d]++;
        end
      end
    end
    m_prev[d] = vb;
  endtask

  task automatic step(input int h, input int v, input logic hs, input logic hb,
                      input logic vs, input logic vb);
    exp_t e1, e2;
    logic [11:0] rgb;
    rgb = rg(h, v);
    model(0, 11'(h), 11'(v), hs, hb, vs, vb, rgb, e1);
    model(1, 11'(h), 11'(v), hs, hb, vs, vb, rgb, e2);
    q1.push_back(e1);
    q2.push_back(e2);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
    @(posedge pclk);
    #1;
    chk("dut1_out", {hco1, vco1, hs1, hb1, vs1, vb1, rgb1}, q1.pop_front());
    chk("dut2_out", {hco2, vco2, hs2, hb2, vs2, vb2, rgb2}, q2.pop_front());
  endtask

  task automatic do_reset(input int n, input logic vb);
    rst = 1'b1;
    vblnk_in = vb;
    repeat (n) begin
      @(posedge pclk);
      #1;
      chk("rst_dut1", {hco1, vco1, hs1, hb1, vs1, vb1, rgb1, xy1, ln1}, 64'd0);
      chk("rst_dut2", {hco2, vco2, hs2, hb2, vs2, vb2, rgb2, xy2, ln2}, 64'd0);
    end
    rst = 1'b0;
    q1.delete();
    q2.delete();
    repeat (3) q1.push_back('0);
    repeat (2) q2.push_back('0);
    model_reset();
  endtask

  task automatic full_line(input int v);
    for (int h = 0; h < 1056; h++) step(h, v, (h >= 1040 && h < 1048), (h >= 1024), 1'b0, 1'b0);
  endtask

  task automatic seg(input int v, input int hs, input int he);
    for (int h = hs; h <= he; h++) step(h, v, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vblank();
    repeat (3) step(0, 768, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int vlist[9] = '{0, 249, 250, 251, 265, 400, 505, 506, 700};
    model_reset();
    do_reset(3, 1'b0);

    // Constant single-pixel glyph column across lines at and around the box edges.
    foreach (vlist[i]) full_line(vlist[i]);
    vblank();

    // Cell/line addressing: column 5, row 9, line 7.
    step(350 + 8 * 5 + 3, 250 + 16 * 9 + 7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("char_xy1", xy1, 8'h95);
    chk("char_line1", ln1, 4'h7);
    chk("char_xy2", xy2, 8'h95);
    step(349, 300, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("char_xy_out", {xy1, ln1}, 12'h000);

    // Blanking inside the box forces black.
    for (int h = 400; h < 406; h++) step(h, 300, 1'b0, 1'b1, 1'b0, 1'b0);
    step(410, 300, 1'b0, 1'b0, 1'b1, 1'b1);
    vblank();

    // Address-dependent glyph pattern.
    rom_mode = 1;
    seg(250, 340, 490); seg(263, 340, 490); seg(377, 340, 490); seg(505, 340, 490);
    vblank();
    rom_mode = 0;
    vblank();

    // Origin change mid-frame takes effect only after the next vblank.
    seg(300, 300, 500);
    xpos = 11'd600;
    seg(301, 300, 800);
    vblank();
    seg(300, 300, 800);
    xpos = 11'd2000;
    vblank();
    seg(300, 0, 100);
    seg(300, 1990, 2047);
    seg(300, 0, 20);
    xpos = 11'd350;
    vblank();

    // Blinking from a known frame count.
    do_reset(1, 1'b0);
    blink_en = 1'b1;
    for (int f = 0; f < 62; f++) begin
      seg(260, 340, 490);
      vblank();
    end
    blink_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      seg(260, 340, 490);
      vblank();
    end

    // Mid-line reset; a vblank edge coinciding with reset must not latch xpos.
    seg(300, 340, 400);
    xpos = 11'd600;
    do_reset(1, 1'b1);
    xpos = 11'd350;
    seg(300, 401, 490);
    seg(301, 340, 490);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
